// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter with a small transmit FIFO in front of
//               the serialiser.
// Revision    : 1.0 - initial release
// ============================================================================

module uart_tx #(
    parameter int CLKS_PER_BIT = 12000000 / 9600,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_valid,
    input  logic [7:0] byte_data,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_PTR_W:0]   c_FULL     = FIFO_DEPTH[c_PTR_W:0];
    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_nonempty;

    // ready depends only on registered occupancy, so a full FIFO that pops
    // this cycle still refuses the push on the same edge.
    assign ready           = (r_count != c_FULL);
    assign w_push          = data_valid & ready & ~reset;
    assign w_fifo_nonempty = (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= byte_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [c_CNT_W-1:0] w_clk_cnt_next;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_next;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_next;
    logic               r_tx;
    logic               w_tx_next;
    logic               w_bit_done;

    assign w_bit_done = (r_clk_cnt == c_BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    // The line level is registered from the current state, so tx trails the
    // state register by one cycle; every bit still lasts CLKS_PER_BIT cycles.
    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = w_bit_done ? '0 : r_clk_cnt + 1'b1;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_tx_next      = 1'b1;
        w_pop          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clk_cnt_next = '0;
                w_bit_idx_next = '0;
                if (w_fifo_nonempty) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_bit_done) begin
                    w_bit_idx_next = '0;
                    w_state_next   = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_next = r_shift[r_bit_idx];
                if (w_bit_done) begin
                    w_bit_idx_next = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                w_tx_next = 1'b1;
                if (w_bit_done) begin
                    // Chain straight into the next start bit when data waits.
                    if (w_fifo_nonempty) begin
                        w_pop        = 1'b1;
                        w_shift_next = r_mem[r_rd_ptr];
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_clk_cnt_next = '0;
                w_bit_idx_next = '0;
            end
        endcase
    end

    assign tx   = r_tx;
    assign busy = (r_state != S_IDLE) || w_fifo_nonempty;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed self-checking bench for uart_tx with a serial-line
//               receiver model feeding a byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_uart_tx;

    localparam int c_CPB   = 4;
    localparam int c_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       ready;
    logic       tx;
    logic       busy;

    uart_tx #(
        .CLKS_PER_BIT (c_CPB),
        .FIFO_DEPTH   (c_DEPTH)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .data_valid (data_valid),
        .byte_data  (byte_data),
        .ready      (ready),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cyc;
        bit         good;
    } frame_t;

    logic [7:0] exp_q[$];
    frame_t     rx_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    bit         rst_seen = 0;
    bit         dead = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (reset) rst_seen = 1;
    end

    // Line receiver: samples every cycle of each bit window on the falling
    // edge, demanding a constant level per window and correct framing.
    initial begin
        frame_t mf;
        logic   v;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && reset === 1'b0) begin
                mf.cyc  = cyc;
                mf.good = 1'b1;
                mf.data = 8'h00;
                rst_seen = 0;
                v = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    for (int j = 0; j < c_CPB; j++) begin
                        if (!(i == 0 && j == 0)) @(negedge clk);
                        if (j == 0) v = tx;
                        else if (tx !== v) mf.good = 1'b0;
                    end
                    if (i == 0 && v !== 1'b0) mf.good = 1'b0;
                    if (i >= 1 && i <= 8) mf.data[i-1] = v;
                    if (i == 9 && v !== 1'b1) mf.good = 1'b0;
                end
                if (!rst_seen) rx_q.push_back(mf);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input string tag, output int fcyc);
        int         t;
        frame_t     f;
        logic [7:0] e;
        t    = 0;
        fcyc = 0;
        while (rx_q.size() == 0 && t < 600 && !dead) begin
            @(negedge clk);
            t++;
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, "_arrive"}, 32'(rx_q.size() != 0), 32'd1);
        if (rx_q.size() == 0) begin
            dead = 1;
        end else begin
            f    = rx_q.pop_front();
            fcyc = f.cyc;
            check({tag, "_byte"}, 32'(f.data), 32'(e));
            check({tag, "_frame"}, 32'(f.good), 32'd1);
        end
    endtask

    initial begin
        int c0;
        int c1;
        int lows;
        int b;
        int t;

        // Reset with data_valid held high: the offered byte must be ignored.
        data_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (3) @(negedge clk);
        reset      = 1'b0;
        data_valid = 1'b0;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (50) @(negedge clk);
        check("rst_dv_ignored_busy", 32'(busy), 32'd0);
        check("rst_dv_ignored_rx", 32'(rx_q.size()), 32'd0);

        // Single byte 0xA5: start bit appears two edges after acceptance.
        data_valid = 1'b1;
        byte_data  = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        data_valid = 1'b0;
        check("a5_k_tx", 32'(tx), 32'd1);
        check("a5_k_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("a5_k1_tx", 32'(tx), 32'd1);
        @(negedge clk);
        check("a5_k2_tx", 32'(tx), 32'd0);
        expect_frame("a5", c0);
        repeat (2) @(negedge clk);
        check("a5_busy_end", 32'(busy), 32'd0);
        check("a5_tx_idle", 32'(tx), 32'd1);

        // Back-to-back 0x00, 0xFF: frames must abut exactly.
        data_valid = 1'b1;
        byte_data  = 8'h00;
        exp_q.push_back(8'h00);
        @(negedge clk);
        byte_data = 8'hFF;
        exp_q.push_back(8'hFF);
        @(negedge clk);
        data_valid = 1'b0;
        expect_frame("b2b0", c0);
        expect_frame("b2b1", c1);
        check("b2b_gap", 32'(c1 - c0), 32'(10 * c_CPB));
        repeat (4) @(negedge clk);
        check("b2b_busy_end", 32'(busy), 32'd0);

        // Stream 0x01..0x06: first pops, FIFO fills, sixth is dropped.
        for (int i = 1; i <= 6; i++) begin
            check("fill_ready", 32'(ready), 32'(i <= 5));
            data_valid = 1'b1;
            byte_data  = 8'(i);
            if (i <= 5) exp_q.push_back(8'(i));
            @(negedge clk);
        end
        data_valid = 1'b0;
        check("full_ready", 32'(ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);

        // Push on the edge a full FIFO pops: rejected, occupancy drops to 3.
        repeat (35) @(negedge clk);
        check("full_before_pop", 32'(ready), 32'd0);
        data_valid = 1'b1;
        byte_data  = 8'h77;
        @(negedge clk);
        data_valid = 1'b0;
        check("full_pop_reject", 32'(ready), 32'd1);

        // Push on a pop edge at occupancy 3: accepted, occupancy stays 3.
        repeat (39) @(negedge clk);
        data_valid = 1'b1;
        byte_data  = 8'h88;
        exp_q.push_back(8'h88);
        @(negedge clk);
        check("pushpop_ready", 32'(ready), 32'd1);
        byte_data = 8'h99;
        exp_q.push_back(8'h99);
        @(negedge clk);
        data_valid = 1'b0;
        check("pushpop_then_full", 32'(ready), 32'd0);
        for (int i = 0; i < 7; i++) expect_frame("stream", c0);
        repeat (4) @(negedge clk);
        check("stream_busy_end", 32'(busy), 32'd0);

        // Reset during data bit 3 of 0x3C with two bytes queued.
        repeat (3) @(negedge clk);
        data_valid = 1'b1;
        byte_data  = 8'h3C;
        @(negedge clk);
        byte_data = 8'h11;
        @(negedge clk);
        byte_data = 8'h22;
        @(negedge clk);
        data_valid = 1'b0;
        check("abort_queued_busy", 32'(busy), 32'd1);
        repeat (16) @(negedge clk);
        check("abort_bit3", 32'(tx), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("abort_line_quiet", 32'(lows), 32'd0);
        check("abort_no_frames", 32'(rx_q.size()), 32'd0);

        // Loopback of every byte value through the line receiver.
        b = 0;
        t = 0;
        while (b < 256 && t < 20000) begin
            data_valid = 1'b1;
            byte_data  = 8'(b);
            if (ready) begin
                exp_q.push_back(8'(b));
                b++;
            end
            @(negedge clk);
            t++;
        end
        data_valid = 1'b0;
        check("loop_all_accepted", 32'(b), 32'd256);
        for (int i = 0; i < 256; i++) expect_frame("loop", c0);
        check("loop_rx_drained", 32'(rx_q.size()), 32'd0);
        check("loop_exp_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
